load_store_unit: RTL and testbench
==================================

// Module: load_store_unit
// PURPOSE
// - Downstream neighbour of the ALU: takes ALU_result as the effective address for RV32I loads/stores.
// - Drives a word-wide data bus with a req/ready handshake, byte enables and store-lane alignment.
// - Returns sign/zero-extended load data to write-back.
// - Stalls the single-cycle core while a bus access is outstanding.
// PARAMETERS
// - ADDR_WIDTH      32   width of addr and bus_addr
// - TIMEOUT_CYCLES  255  max WAIT cycles before the access is aborted; must be >=1
// - TO_CNT_W        8    timeout counter width; must satisfy 2**TO_CNT_W > TIMEOUT_CYCLES
// PORTS
// - clk          in   1           rising-edge clock
// - rst          in   1           synchronous, active-high reset
// - mem_read     in   1           control: current instruction is a load
// - mem_write    in   1           control: current instruction is a store (never high together with mem_read)
// - funct3       in   3           access size/sign (000 B, 001 H, 010 W, 100 BU, 101 HU)
// - addr         in   ADDR_WIDTH  effective address (ALU_result)
// - store_data   in   32          rs2 value
// - load_data    out  32          extended load result, registered
// - stall        out  1           hold PC/regfile this cycle
// - misaligned   out  1           pulse: H not 2-aligned or W not 4-aligned
// - access_fault out  1           pulse: illegal funct3, or bus timeout
// - bus_req      out  1           request, held until bus_ready
// - bus_we       out  1           1 = write
// - bus_addr     out  ADDR_WIDTH  word-aligned address, addr[1:0] = 00
// - bus_be       out  4           byte enables
// - bus_wdata    out  32          lane-shifted store data
// - bus_ready    in   1           bus completes the access this cycle
// - bus_rdata    in   32          read word, valid when bus_ready
// BEHAVIOUR
// - Reset: state=IDLE, bus_req=0, bus_we=0, bus_addr=0, bus_be=0, bus_wdata=0, load_data=0, counter=0.
// - misaligned and access_fault are 0 during reset.
// - FSM states: IDLE, WAIT, DONE.
// - IDLE: access = mem_read|mem_write.
//   - Legal and aligned: register bus_* outputs, set bus_req=1, go to WAIT. stall=1 combinationally in this cycle.
//   - Misaligned, or illegal funct3 (incl. stores with funct3[2]=1): no bus activity, stall=0.
//     misaligned or access_fault goes high combinationally for this cycle only; misaligned takes priority.
// - WAIT: stall=1; bus_* outputs stay stable.
//   - bus_ready=1: bus_req<=0. For loads, load_data<=extract(bus_rdata); then go to DONE.
//   - Counter reaches TIMEOUT_CYCLES: bus_req<=0, load_data<=0, set a fault flag, go to DONE.
// - DONE: stall=0; load_data is valid for the core to consume.
//   - access_fault=1 if the fault flag is set.
//   - Inputs ignored (same instruction is still presented). Next state IDLE.
// - Minimum latency is 2 stall cycles (launch, 1-cycle ready), then the DONE cycle.
// - Byte enables: B 0001<<a[1:0]; H 0011<<a[1:0]; W 1111.
// - Store data: B replicated to 4 lanes, H replicated to 2 lanes, W as is.
// - Load extract: select the lane by the registered addr[1:0]. B/H sign-extend; BU/HU zero-extend.
// - bus_ready while in IDLE or DONE: ignored.
// - Reset mid-access: next cycle IDLE with bus_req=0. The outstanding transaction is abandoned and any late bus_ready is ignored.
// - load_data holds its value except on a load completion or a timeout.
// STRUCTURE
// - Package lsu_pkg holds:
//   - funct3 localparams: F3_B, F3_H, F3_W, F3_BU, F3_HU
//   - state typedef/localparams: S_IDLE, S_WAIT, S_DONE
// - Sub-module lsu_lane_align, purely combinational:
//   - store path: funct3 + addr[1:0] + store_data -> be, wdata, misaligned, illegal
//   - load path: registered funct3 + addr[1:0] + bus_rdata -> extended load word
// - Top module holds the FSM, timeout counter and output registers.
// TESTING
// - LW addr=0x100, bus_ready 1 cycle after req, rdata=0xDEADBEEF:
//   stall high 2 cycles, bus_addr=0x100, be=1111, load_data=0xDEADBEEF in DONE.
// - LB addr=0x103, rdata=0x80xxxxxx -> be=1000, load_data=0xFFFFFF80.
//   Same access with LBU -> 0x00000080.
// - SH addr=0x202, store_data=0x1234ABCD -> bus_we=1, be=1100, bus_wdata=0xABCDABCD, bus_addr=0x200.
// - LW addr=0x101 -> misaligned pulses for 1 cycle; bus_req stays 0; stall=0.
//   Store with funct3=100 -> access_fault pulses for 1 cycle; no bus activity.
// - TIMEOUT_CYCLES=4, bus_ready never asserted:
//   bus_req drops after 4 WAIT cycles, DONE has access_fault=1 and load_data=0.
// - rst asserted in WAIT, then bus_ready pulses 2 cycles later:
//   bus_req=0 the cycle after rst, state stays IDLE, load_data stays 0.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV32I funct3 access codes
// and the bus-access FSM state encoding.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } lsu_state_e;

endpackage

// File: rtl/lsu_lane_align.sv
// Purely combinational lane logic for the load/store unit.
// Store path: funct3_i/addr_lo_i/store_data_i -> be_o, wdata_o, misaligned_o, illegal_o.
// Load path : ld_funct3_i/ld_addr_lo_i/rdata_i -> ld_data_o (sign/zero extended).
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  addr_lo_i,
  input  logic        is_store_i,
  input  logic [31:0] store_data_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic        misaligned_o,
  output logic        illegal_o,
  input  logic [2:0]  ld_funct3_i,
  input  logic [1:0]  ld_addr_lo_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] ld_data_o
);

  logic [31:0] rshift;

  always_comb begin
    be_o         = 4'b0000;
    wdata_o      = store_data_i;
    misaligned_o = 1'b0;
    illegal_o    = 1'b0;
    case (funct3_i)
      F3_B, F3_BU: begin
        be_o    = 4'b0001 << addr_lo_i;
        wdata_o = {4{store_data_i[7:0]}};
      end
      F3_H, F3_HU: begin
        be_o         = 4'b0011 << addr_lo_i;
        wdata_o      = {2{store_data_i[15:0]}};
        misaligned_o = addr_lo_i[0];
      end
      F3_W: begin
        be_o         = 4'b1111;
        misaligned_o = |addr_lo_i;
      end
      default: illegal_o = 1'b1;
    endcase
    // Unsigned variants only exist for loads.
    if (is_store_i && funct3_i[2]) illegal_o = 1'b1;
  end

  // Bring the addressed lane down to bit 0; halfword/word accesses are
  // already known aligned, so a plain byte-granular shift suffices.
  assign rshift = rdata_i >> {ld_addr_lo_i, 3'b000};

  always_comb begin
    case (ld_funct3_i)
      F3_B:    ld_data_o = {{24{rshift[7]}}, rshift[7:0]};
      F3_BU:   ld_data_o = {24'h0, rshift[7:0]};
      F3_H:    ld_data_o = {{16{rshift[15]}}, rshift[15:0]};
      F3_HU:   ld_data_o = {16'h0, rshift[15:0]};
      default: ld_data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit. Takes the ALU result as effective address, runs
// one req/ready bus access per load/store, stalls the core meanwhile and
// returns extended load data to write-back.
// Ports: clk/rst (sync, active high); mem_read/mem_write/funct3/addr/
// store_data from the core; load_data/stall/misaligned/access_fault back
// to the core; bus_req/we/addr/be/wdata out and bus_ready/rdata in.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TO_CNT_W       = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic [2:0]            funct3,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           store_data,
  output logic [31:0]           load_data,
  output logic                  stall,
  output logic                  misaligned,
  output logic                  access_fault,
  output logic                  bus_req,
  output logic                  bus_we,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic [3:0]            bus_be,
  output logic [31:0]           bus_wdata,
  input  logic                  bus_ready,
  input  logic [31:0]           bus_rdata
);

  lsu_state_e            state_q, state_d;
  logic [TO_CNT_W-1:0]   cnt_q, cnt_d;
  logic                  fault_q, fault_d;
  logic                  req_q, req_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [3:0]            be_q, be_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [31:0]           ld_q, ld_d;
  logic [2:0]            f3_q, f3_d;
  logic [1:0]            lo_q, lo_d;

  logic [3:0]  al_be;
  logic [31:0] al_wdata, al_ld;
  logic        al_mis, al_ill, access;

  lsu_lane_align u_align (
    .funct3_i     (funct3),
    .addr_lo_i    (addr[1:0]),
    .is_store_i   (mem_write),
    .store_data_i (store_data),
    .be_o         (al_be),
    .wdata_o      (al_wdata),
    .misaligned_o (al_mis),
    .illegal_o    (al_ill),
    .ld_funct3_i  (f3_q),
    .ld_addr_lo_i (lo_q),
    .rdata_i      (bus_rdata),
    .ld_data_o    (al_ld)
  );

  assign access = mem_read | mem_write;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    fault_d      = fault_q;
    req_d        = req_q;
    we_d         = we_q;
    addr_d       = addr_q;
    be_d         = be_q;
    wdata_d      = wdata_q;
    ld_d         = ld_q;
    f3_d         = f3_q;
    lo_d         = lo_q;
    stall        = 1'b0;
    misaligned   = 1'b0;
    access_fault = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (access) begin
          if (al_mis) begin
            misaligned = 1'b1;
          end else if (al_ill) begin
            access_fault = 1'b1;
          end else begin
            stall   = 1'b1;
            req_d   = 1'b1;
            we_d    = mem_write;
            addr_d  = {addr[ADDR_WIDTH-1:2], 2'b00};
            be_d    = al_be;
            wdata_d = mem_write ? al_wdata : 32'h0;
            f3_d    = funct3;
            lo_d    = addr[1:0];
            cnt_d   = '0;
            fault_d = 1'b0;
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        stall = 1'b1;
        // A ready in the last allowed cycle still wins over the timeout.
        if (bus_ready) begin
          req_d   = 1'b0;
          if (!we_q) ld_d = al_ld;
          state_d = S_DONE;
        end else if (cnt_q == TO_CNT_W'(TIMEOUT_CYCLES - 1)) begin
          req_d   = 1'b0;
          ld_d    = 32'h0;
          fault_d = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE: begin
        access_fault = fault_q;
        cnt_d        = '0;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (rst) begin
      stall        = 1'b0;
      misaligned   = 1'b0;
      access_fault = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      fault_q <= 1'b0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      be_q    <= 4'b0000;
      wdata_q <= 32'h0;
      ld_q    <= 32'h0;
      f3_q    <= 3'b000;
      lo_q    <= 2'b00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fault_q <= fault_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      ld_q    <= ld_d;
      f3_q    <= f3_d;
      lo_q    <= lo_d;
    end
  end

  assign bus_req   = req_q;
  assign bus_we    = we_q;
  assign bus_addr  = addr_q;
  assign bus_be    = be_q;
  assign bus_wdata = wdata_q;
  assign load_data = ld_q;

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_read = 1'b0, mem_write = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] addr = 32'h0, store_data = 32'h0;
  logic [31:0] load_data, bus_addr, bus_wdata;
  logic        stall, misaligned, access_fault, bus_req, bus_we;
  logic [3:0]  bus_be;
  logic        bus_ready = 1'b0;
  logic [31:0] bus_rdata = 32'h0;

  always #5 clk = ~clk;

  load_store_unit #(.ADDR_WIDTH(32), .TIMEOUT_CYCLES(TO), .TO_CNT_W(3)) dut (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
    .funct3(funct3), .addr(addr), .store_data(store_data),
    .load_data(load_data), .stall(stall), .misaligned(misaligned),
    .access_fault(access_fault), .bus_req(bus_req), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata),
    .bus_ready(bus_ready), .bus_rdata(bus_rdata)
  );

  // kind: 0 = bus access, 1 = misaligned, 2 = access fault (no bus)
  typedef struct {
    int          kind;
    logic        we;
    logic [31:0] baddr;
    logic [3:0]  be;
    logic [31:0] wdata;
    int          stalls;
    logic        to;
    logic [31:0] ld;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0, errors = 0;
  logic [31:0] model_ld = 32'h0;
  int          cur_delay = 0;
  bit          cur_never = 1'b0;
  logic [31:0] cur_rdata = 32'h0;
  bit          resp_en = 1'b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Reference model: access outcome from size/offset arithmetic.
  function automatic exp_t model(bit rd, bit wr, logic [2:0] f3, logic [31:0] a,
                                 logic [31:0] sd, int dly, bit never, logic [31:0] rdata);
    exp_t        e;
    int          size, off;
    int unsigned v;
    off = int'(a % 4);
    case (f3)
      3'd0, 3'd4: size = 1;
      3'd1, 3'd5: size = 2;
      3'd2:       size = 4;
      default:    size = 0;
    endcase
    e.kind = 0; e.we = wr; e.baddr = a - 32'(off); e.be = 4'h0; e.wdata = 32'h0;
    e.stalls = 0; e.to = 1'b0; e.ld = model_ld;
    if (size > 1 && (off % size) != 0)       e.kind = 1;
    else if (size == 0 || (wr && f3 >= 4))   e.kind = 2;
    else begin
      if (size == 4)      e.be = 4'hF;
      else if (size == 2) e.be = 4'(3 << off);
      else                e.be = 4'(1 << off);
      if (wr) begin
        if (size == 1)      e.wdata = {sd[7:0], sd[7:0], sd[7:0], sd[7:0]};
        else if (size == 2) e.wdata = {sd[15:0], sd[15:0]};
        else                e.wdata = sd;
      end
      if (never) begin
        e.stalls = 1 + TO; e.to = 1'b1; e.ld = 32'h0;
      end else begin
        e.stalls = 2 + dly;
        if (rd) begin
          v = (rdata >> (8 * off));
          if (size == 1) begin
            v = v % 256;
            if (f3 == 3'd0 && v >= 128) v = v + 32'hFFFF_FF00;
          end else if (size == 2) begin
            v = v % 65536;
            if (f3 == 3'd1 && v >= 32768) v = v + 32'hFFFF_0000;
          end
          e.ld = v;
        end
      end
    end
    return e;
  endfunction

  // Bus responder: ready after cur_delay WAIT cycles unless cur_never.
  int wcnt = 0;
  always @(negedge clk) begin
    if (resp_en) begin
      if (bus_req) begin
        bus_ready = (!cur_never && wcnt == cur_delay);
        bus_rdata = bus_ready ? cur_rdata : $urandom;
        wcnt++;
      end else begin
        bus_ready = 1'b0;
        wcnt = 0;
      end
    end
  end

  // Monitor: pops an expectation whenever the DUT starts reacting.
  exp_t cur;
  bit   in_acc = 1'b0;
  int   scnt = 0;
  always @(negedge clk) begin
    if (rst) begin
      in_acc = 1'b0;
    end else if (!in_acc) begin
      if (misaligned || access_fault || stall) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_event mis=%b af=%b stall=%b", misaligned, access_fault, stall);
        end else begin
          cur = exp_q.pop_front();
          if (stall) begin
            chk("launch_kind", 32'(0), 32'(cur.kind));
            chk("launch_pulses", {30'h0, misaligned, access_fault}, 32'h0);
            in_acc = 1'b1;
            scnt = 1;
          end else begin
            chk("fault_kind", misaligned ? 32'd1 : 32'd2, 32'(cur.kind));
            chk("fault_no_req", 32'(bus_req), 32'h0);
          end
        end
      end
    end else if (stall) begin
      scnt++;
      if (scnt == 2) begin
        chk("bus_req", 32'(bus_req), 32'h1);
        chk("bus_we", 32'(bus_we), 32'(cur.we));
        chk("bus_addr", bus_addr, cur.baddr);
        chk("bus_be", 32'(bus_be), 32'(cur.be));
        if (cur.we) chk("bus_wdata", bus_wdata, cur.wdata);
      end
    end else begin
      chk("stall_cycles", 32'(scnt), 32'(cur.stalls));
      chk("done_fault", 32'(access_fault), 32'(cur.to));
      chk("load_data", load_data, cur.ld);
      chk("done_req", 32'(bus_req), 32'h0);
      in_acc = 1'b0;
    end
  end

  task automatic run_op(input bit rd, input bit wr, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] sd, input int dly, input bit never, input logic [31:0] rdata);
    exp_t e;
    bit   done;
    e = model(rd, wr, f3, a, sd, dly, never, rdata);
    exp_q.push_back(e);
    if (e.kind == 0) model_ld = e.ld;
    cur_delay = dly; cur_never = never; cur_rdata = rdata;
    mem_read = rd; mem_write = wr; funct3 = f3; addr = a; store_data = sd;
    if (e.kind != 0) begin
      @(posedge clk); #1;
    end else begin
      done = 1'b0;
      for (int i = 0; i < 30 && !done; i++) begin
        @(posedge clk); #1;
        if (!stall) done = 1'b1;
      end
      if (!done) begin
        checks++; errors++;
        $display("FAIL op_bound stall=%b expected=0", stall);
      end
      @(posedge clk); #1;  // DONE cycle: same instruction still presented
    end
    mem_read = 1'b0; mem_write = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    bit          rd;
    logic [2:0]  f3;
    logic [2:0]  legal [5];
    legal[0] = 3'd0; legal[1] = 3'd1; legal[2] = 3'd2; legal[3] = 3'd4; legal[4] = 3'd5;

    // Reset state, with a misaligned load presented to show pulses are masked.
    mem_read = 1'b1; funct3 = 3'd2; addr = 32'h1;
    repeat (2) @(negedge clk);
    chk("rst_mis", 32'(misaligned), 32'h0);
    chk("rst_af", 32'(access_fault), 32'h0);
    chk("rst_stall", 32'(stall), 32'h0);
    chk("rst_req", 32'(bus_req), 32'h0);
    chk("rst_we", 32'(bus_we), 32'h0);
    chk("rst_addr", bus_addr, 32'h0);
    chk("rst_be", 32'(bus_be), 32'h0);
    chk("rst_wdata", bus_wdata, 32'h0);
    chk("rst_ld", load_data, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0; mem_read = 1'b0; addr = 32'h0;
    @(posedge clk); #1;

    // Directed cases.
    run_op(1, 0, 3'd2, 32'h100, 32'h0, 0, 0, 32'hDEADBEEF);
    run_op(1, 0, 3'd0, 32'h103, 32'h0, 1, 0, 32'h80123456);
    run_op(1, 0, 3'd4, 32'h103, 32'h0, 0, 0, 32'h80123456);
    run_op(0, 1, 3'd1, 32'h202, 32'h1234ABCD, 0, 0, 32'h0);
    run_op(1, 0, 3'd2, 32'h101, 32'h0, 0, 0, 32'h0);
    run_op(0, 1, 3'd4, 32'h204, 32'h55, 0, 0, 32'h0);
    run_op(1, 0, 3'd5, 32'h402, 32'h0, 3, 0, 32'h8001F234);
    run_op(1, 0, 3'd2, 32'h300, 32'h0, 0, 1, 32'h0);
    run_op(1, 0, 3'd1, 32'h306, 32'h0, 2, 0, 32'h9ABC0000);
    run_op(0, 1, 3'd0, 32'h307, 32'hA5A5A5C3, 0, 1, 32'h0);

    // Randomized traffic.
    for (int n = 0; n < 150; n++) begin
      rd = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 4) == 0) f3 = 3'($urandom_range(0, 7));
      else                           f3 = legal[$urandom_range(0, 4)];
      run_op(rd, !rd, f3, $urandom, $urandom, int'($urandom_range(0, 3)),
             ($urandom_range(0, 9) == 0), $urandom);
      if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
    end

    // Reset in WAIT followed by a late bus_ready.
    resp_en = 1'b0; bus_ready = 1'b0;
    exp_q.push_back(model(1, 0, 3'd2, 32'h500, 32'h0, 0, 1, 32'h0));
    mem_read = 1'b1; funct3 = 3'd2; addr = 32'h500;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b1; mem_read = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    chk("midrst_req", 32'(bus_req), 32'h0);
    chk("midrst_stall", 32'(stall), 32'h0);
    @(posedge clk); #1;
    bus_ready = 1'b1; bus_rdata = 32'h12345678;
    @(posedge clk); #1;
    bus_ready = 1'b0;
    @(posedge clk); #1;
    chk("late_rdy_req", 32'(bus_req), 32'h0);
    chk("late_rdy_stall", 32'(stall), 32'h0);
    chk("late_rdy_ld", load_data, 32'h0);
    model_ld = 32'h0;
    resp_en = 1'b1;
    run_op(1, 0, 3'd2, 32'h600, 32'h0, 0, 0, 32'hCAFEF00D);

    @(posedge clk); #1;
    chk("queue_empty", 32'(exp_q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
